// File: rtl/sram_axi_bridge_mp_pkg.sv
// Shared types and constants for the multi-port SRAM-like to AXI3 bridge.
// Holds the FSM state encoding, AXI field constants and write-strobe generation.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B
    } state_e;

    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Byte lanes of a 32-bit bus touched by an access of the given size.
    function automatic logic [3:0] gen_strb(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: gen_strb = 4'b0001 << addr_lo;
            SIZE_HALF: gen_strb = 4'b0011 << {addr_lo[1], 1'b0};
            default:   gen_strb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_axi_bridge_mp_if.sv
// Bus bundles for the bridge: NUM_PORTS SRAM-like masters and one AXI3 master link.
// master modport belongs to whoever initiates requests on that bus.
interface sram_mp_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        wr;
    logic [NUM_PORTS*2-1:0]      size;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS*8-1:0]      burst_len;
    logic [DATA_W-1:0]           rdata;
    logic [NUM_PORTS-1:0]        addr_ok;
    logic [NUM_PORTS-1:0]        data_ok;
    logic [NUM_PORTS-1:0]        data_last;

    modport master (
        output req, wr, size, addr, wdata, burst_len,
        input  rdata, addr_ok, data_ok, data_last
    );
    modport slave (
        input  req, wr, size, addr, wdata, burst_len,
        output rdata, addr_ok, data_ok, data_last
    );
endinterface

interface axi3_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first requester at or after the pointer.
// The pointer moves past the winner on every granted cycle; no grant while en_i is low.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        ptr_d     = ptr_q;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (en_i && !gnt_vld_o && req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDX_W'(j);
                ptr_d     = (j + 1 >= N) ? '0 : IDX_W'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_axi_bridge_mp.sv
// NUM_PORTS SRAM-like masters round-robin onto one AXI3 master, one transaction in flight; reads may burst.
// addr_ok is combinational, data_ok registered; BRIDGE_RESP_ERR_EN adds resp_err_o/err_seen_o.
module sram_axi_bridge_mp
    import bridge_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_LEN   = 8
) (
    input  logic     clk,
    input  logic     resetn,
    sram_mp_if.slave sram,
    axi3_if.master   axi
`ifdef BRIDGE_RESP_ERR_EN
    ,
    output logic [NUM_PORTS-1:0] resp_err_o,
    output logic [NUM_PORTS-1:0] err_seen_o
`endif
);

    localparam int         IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);

    state_e               state_q, state_d;
    logic                 active_q;
    logic                 grant_en, gnt_vld;
    logic [NUM_PORTS-1:0] gnt, own_oh;
    logic [IDX_W-1:0]     gnt_idx, own_q;
    logic [1:0]           size_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [7:0]           len_q, blen_sel;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [NUM_PORTS-1:0] data_ok_q, data_ok_d, data_last_q, data_last_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 arvalid, awvalid, wvalid, rready, bready;
    logic                 unused_ids;

    // Hold off a new grant while the previous transaction's data_ok is still visible.
    assign grant_en = active_q && (state_q == ST_IDLE) && !(|data_ok_q);

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (sram.req),
        .en_i      (grant_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign blen_sel = sram.burst_len[gnt_idx*8 +: 8];
    assign own_oh   = NUM_PORTS'(1) << own_q;

`ifdef BRIDGE_RESP_ERR_EN
    logic [NUM_PORTS-1:0] resp_err_d, resp_err_q, err_seen_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, axi.bresp};
`endif
    assign unused_ids = ^{axi.rid, axi.bid};

    always_comb begin
        state_d     = state_q;
        arvalid     = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        rready      = 1'b0;
        bready      = 1'b0;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        data_ok_d   = '0;
        data_last_d = '0;
        rdata_d     = rdata_q;
`ifdef BRIDGE_RESP_ERR_EN
        resp_err_d  = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d   = sram.wr[gnt_idx] ? ST_WR : ST_AR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (axi.arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (axi.rvalid) begin
                    data_ok_d   = own_oh;
                    data_last_d = axi.rlast ? own_oh : '0;
                    rdata_d     = axi.rdata;
`ifdef BRIDGE_RESP_ERR_EN
                    resp_err_d  = (axi.rresp != AXI_RESP_OKAY) ? own_oh : '0;
`endif
                    if (axi.rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && axi.awready) begin
                    aw_done_d = 1'b1;
                end
                if (wvalid && axi.wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (axi.bvalid) begin
                    data_ok_d  = own_oh;
`ifdef BRIDGE_RESP_ERR_EN
                    resp_err_d = (axi.bresp != AXI_RESP_OKAY) ? own_oh : '0;
`endif
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            data_ok_q   <= '0;
            data_last_q <= '0;
            rdata_q     <= '0;
        end else begin
            active_q    <= 1'b1;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            data_ok_q   <= data_ok_d;
            data_last_q <= data_last_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
        end else if (gnt_vld) begin
            own_q   <= gnt_idx;
            size_q  <= sram.size[gnt_idx*2 +: 2];
            addr_q  <= sram.addr[gnt_idx*ADDR_W +: ADDR_W];
            wdata_q <= sram.wdata[gnt_idx*DATA_W +: DATA_W];
            len_q   <= (blen_sel > LEN_CAP) ? LEN_CAP : blen_sel;
        end
    end

`ifdef BRIDGE_RESP_ERR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_err_q <= '0;
            err_seen_q <= '0;
        end else begin
            resp_err_q <= resp_err_d;
            err_seen_q <= err_seen_q | resp_err_d;
        end
    end
    assign resp_err_o = resp_err_q;
    assign err_seen_o = err_seen_q;
`endif

    assign axi.arid    = ID_W'(own_q);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = (len_q == 8'd0) ? {1'b0, size_q} : 3'd2;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid;
    assign axi.rready  = rready;

    assign axi.awid    = ID_W'(own_q);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid;
    assign axi.wid     = ID_W'(own_q);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = gen_strb(size_q, addr_q[1:0]);
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid;
    assign axi.bready  = bready;

    assign sram.rdata     = rdata_q;
    assign sram.addr_ok   = gnt;
    assign sram.data_ok   = data_ok_q;
    assign sram.data_last = data_last_q;

endmodule
